dot_product_ctrl: RTL and testbench
===================================

DOT_PRODUCT_CTRL -- requirements
Module: dot_product_ctrl

Interface
REQ-001 SHALL have parameter nb, default 16: operand width; it matches the attached multiplier_nb instance.
REQ-002 SHALL have parameter DEPTH, default 4: operand FIFO depth, a power of two and at least 2.
REQ-003 SHALL have parameter GB, default 4: accumulator guard bits; ACCW = 2*nb+GB.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 in_valid  input  1  operand pair offered.
REQ-007 in_ready  output  1  FIFO can accept a pair; equals FIFO not full.
REQ-008 in_a, in_b  input  nb each  signed operands.
REQ-009 in_last  input  1  marks the final pair of a dot-product group.
REQ-010 mul_start  output  1  one-cycle start pulse to the multiplier.
REQ-011 mul_A, mul_B  output  nb each  operands to the multiplier; held stable while mul_start=1.
REQ-012 mul_Product  input  2*nb  signed multiplier result.
REQ-013 mul_ready  input  1  multiplier result valid (level).
REQ-014 out_valid  output  1  group result available.
REQ-015 out_ready  input  1  consumer accepts the result.
REQ-016 out_sum  output  ACCW  signed group sum.
REQ-017 out_ovf  output  1  signed overflow occurred in the group.
REQ-018 busy  output  1  high in any state other than IDLE.

Function
REQ-019 Push: a pair and its last flag enter the FIFO when in_valid && in_ready. Pop: FIFO head is removed at ISSUE.
REQ-020 Simultaneous push and pop when full SHALL NOT be allowed: in_ready=0 blocks the push. Simultaneous push and pop when empty is impossible because ISSUE requires non-empty. Otherwise simultaneous push and pop leaves the count unchanged. Pointers wrap modulo DEPTH.
REQ-021 The FSM SHALL have states IDLE, ISSUE, WAIT, ACC and OUT.
REQ-022 IDLE -> ISSUE when the FIFO is non-empty.
REQ-023 ISSUE lasts one cycle: mul_start=1, mul_A/mul_B = FIFO head, head popped and latched with its last flag. Next state is WAIT.
REQ-024 WAIT ignores mul_ready during the first cycle after ISSUE, which guards against a stale ready. From the second cycle on, mul_ready=1 -> ACC. There is no timeout; the multiplier latency is nb+1 cycles, but the design SHALL NOT depend on it.
REQ-025 ACC, one cycle: acc <= acc + sign-extended mul_Product, wrapping modulo 2^ACCW. Set ovf if both operands have the same sign and the result sign differs. Next state is OUT if the latched last flag is 1, else IDLE.
REQ-026 OUT: out_valid=1; out_sum=acc; out_ovf=ovf. Held stable until out_ready=1.
REQ-027 On the out_valid && out_ready cycle: acc <= 0, ovf <= 0, next state IDLE.
REQ-028 The minimum issue-to-issue spacing is 4 cycles beyond the multiplier latency. The FIFO keeps accepting input during WAIT, ACC and OUT.
REQ-029 mul_start SHALL be high only in ISSUE. mul_A/mul_B hold their last issued values otherwise.
REQ-030 in_ready is combinational from the FIFO count only, with no dependence on in_valid.

Reset
REQ-031 While rst=1, asynchronously: FSM=IDLE, FIFO empty, acc=0, ovf=0, mul_start=0, mul_A=mul_B=0, out_valid=0, out_sum=0, out_ovf=0, busy=0, in_ready=1.
REQ-032 Reset mid-operation discards queued pairs and the partial sum. A multiplier result still in flight SHALL be ignored, because IDLE ignores mul_ready.
REQ-033 The first push is accepted on the first rising edge with rst=0.

Verification (nb=8, DEPTH=4, GB=4, ACCW=20, real multiplier_nb attached)
REQ-034 Push (3,4), (-5,6), (7,-2, last) with out_ready=1 -> single out_valid pulse with out_sum=-32 and out_ovf=0.
REQ-035 Push a single (-128,-128, last) -> out_sum=16384; mul_start is seen exactly once, one cycle wide.
REQ-036 Hold out_ready=0 for 20 cycles after out_valid rises, then raise it -> out_sum stays stable throughout; the next group starts from 0.
REQ-037 While a group is in WAIT, push 5 pairs back-to-back -> in_ready=0 after the FIFO reaches 4 entries; the 5th pair is accepted only after the next ISSUE pop.
REQ-038 Push 32 pairs of (-128,-128), the last with last=1 -> out_sum=-524288 (wrapped) and out_ovf=1.
REQ-039 Assert rst for 1 cycle during WAIT of (10,10) -> all outputs take their reset values immediately. A following (2,3, last) yields out_sum=6.

Source files
------------

// File: rtl/dot_product_ctrl_if.sv
// Bus bundle for dot_product_ctrl: operand stream in, multiplier handshake, group result out.
// The slave modport is the controller; the master modport is its environment.
interface dot_product_ctrl_if #(
    parameter int unsigned nb = 16,
    parameter int unsigned GB = 4
);
    localparam int unsigned ACCW = 2 * nb + GB;

    logic              in_valid;
    logic              in_ready;
    logic [nb-1:0]     in_a;
    logic [nb-1:0]     in_b;
    logic              in_last;

    logic              mul_start;
    logic [nb-1:0]     mul_A;
    logic [nb-1:0]     mul_B;
    logic [2*nb-1:0]   mul_Product;
    logic              mul_ready;

    logic              out_valid;
    logic              out_ready;
    logic [ACCW-1:0]   out_sum;
    logic              out_ovf;

    modport master (
        output in_valid, in_a, in_b, in_last, mul_Product, mul_ready, out_ready,
        input  in_ready, mul_start, mul_A, mul_B, out_valid, out_sum, out_ovf
    );

    modport slave (
        input  in_valid, in_a, in_b, in_last, mul_Product, mul_ready, out_ready,
        output in_ready, mul_start, mul_A, mul_B, out_valid, out_sum, out_ovf
    );
endinterface

// File: rtl/dot_product_ctrl.sv
// Dot-product sequencer: buffers signed operand pairs, drives an external multiplier
// one pair at a time and accumulates products until a pair flagged last closes the group.
module dot_product_ctrl #(
    parameter int unsigned nb    = 16,
    parameter int unsigned DEPTH = 4,
    parameter int unsigned GB    = 4
) (
    input  logic                clk,
    input  logic                rst,
    dot_product_ctrl_if.slave   bus,
    output logic                busy
);
    localparam int unsigned ACCW = 2 * nb + GB;
    localparam int unsigned PW   = 2 * nb;
    localparam int unsigned PTRW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNTW = PTRW + 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_ACC,
        S_OUT
    } state_t;

    typedef struct packed {
        logic          last;
        logic [nb-1:0] a;
        logic [nb-1:0] b;
    } entry_t;

    entry_t            mem_q [DEPTH];
    logic [PTRW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTRW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNTW-1:0]   count_q, count_d;
    state_t            state_q, state_d;
    logic              armed_q, armed_d;
    logic              last_q, last_d;
    logic [ACCW-1:0]   acc_q, acc_d;
    logic              ovf_q, ovf_d;
    logic              mul_start_q, mul_start_d;
    logic [nb-1:0]     mul_a_q, mul_a_d;
    logic [nb-1:0]     mul_b_q, mul_b_d;
    logic              out_valid_q, out_valid_d;
    logic              busy_q, busy_d;

    logic              fifo_full;
    logic              fifo_empty;
    logic              push;
    logic              pop;
    entry_t            head;
    logic [ACCW-1:0]   prod_ext;
    logic [ACCW-1:0]   sum;

    assign fifo_full  = (count_q == CNTW'(DEPTH));
    assign fifo_empty = (count_q == '0);
    assign push       = bus.in_valid && !fifo_full;
    assign pop        = (state_q == S_ISSUE);
    assign head       = mem_q[rd_ptr_q];
    assign prod_ext   = {{GB{bus.mul_Product[PW-1]}}, bus.mul_Product};
    assign sum        = acc_q + prod_ext;

    // Operand storage; occupancy is tracked by the reset pointers, so no reset here.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= entry_t'{last: bus.in_last, a: bus.in_a, b: bus.in_b};
        end
    end

    always_comb begin
        state_d  = state_q;
        armed_d  = (state_q == S_WAIT);
        last_d   = last_q;
        acc_d    = acc_q;
        ovf_d    = ovf_q;
        mul_a_d  = mul_a_q;
        mul_b_d  = mul_b_q;
        wr_ptr_d = wr_ptr_q + PTRW'(push);
        rd_ptr_d = rd_ptr_q + PTRW'(pop);
        count_d  = count_q + CNTW'(push) - CNTW'(pop);

        case (state_q)
            S_IDLE: begin
                // Head is captured on entry so the operands are already stable during ISSUE.
                if (!fifo_empty) begin
                    state_d = S_ISSUE;
                    mul_a_d = head.a;
                    mul_b_d = head.b;
                    last_d  = head.last;
                end
            end
            S_ISSUE: state_d = S_WAIT;
            S_WAIT: begin
                // armed_q is low in the first WAIT cycle, masking a ready left over from before.
                if (armed_q && bus.mul_ready) begin
                    state_d = S_ACC;
                end
            end
            S_ACC: begin
                acc_d = sum;
                if ((acc_q[ACCW-1] == prod_ext[ACCW-1]) && (sum[ACCW-1] != acc_q[ACCW-1])) begin
                    ovf_d = 1'b1;
                end
                state_d = last_q ? S_OUT : S_IDLE;
            end
            S_OUT: begin
                if (bus.out_ready) begin
                    acc_d   = '0;
                    ovf_d   = 1'b0;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        mul_start_d = (state_d == S_ISSUE);
        out_valid_d = (state_d == S_OUT);
        busy_d      = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            armed_q     <= 1'b0;
            last_q      <= 1'b0;
            acc_q       <= '0;
            ovf_q       <= 1'b0;
            mul_start_q <= 1'b0;
            mul_a_q     <= '0;
            mul_b_q     <= '0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            armed_q     <= armed_d;
            last_q      <= last_d;
            acc_q       <= acc_d;
            ovf_q       <= ovf_d;
            mul_start_q <= mul_start_d;
            mul_a_q     <= mul_a_d;
            mul_b_q     <= mul_b_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
        end
    end

    assign bus.in_ready  = !fifo_full;
    assign bus.mul_start = mul_start_q;
    assign bus.mul_A     = mul_a_q;
    assign bus.mul_B     = mul_b_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_sum   = acc_q;
    assign bus.out_ovf   = ovf_q;
    assign busy          = busy_q;
endmodule

// File: tb/tb_dot_product_ctrl.sv
// Scoreboard bench for dot_product_ctrl with a behavioural nb+1 cycle multiplier attached.
module tb_dot_product_ctrl;
    localparam int unsigned NB    = 8;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned GB    = 4;
    localparam int unsigned ACCW  = 2 * NB + GB;
    localparam int unsigned LAT   = NB + 1;

    typedef struct packed {
        logic [ACCW-1:0] sum;
        logic            ovf;
    } result_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic busy;

    dot_product_ctrl_if #(.nb(NB), .GB(GB)) bus ();

    dot_product_ctrl #(.nb(NB), .DEPTH(DEPTH), .GB(GB)) dut (
        .clk  (clk),
        .rst  (rst),
        .bus  (bus),
        .busy (busy)
    );

    always #5 clk = ~clk;

    result_t exp_q[$];
    int total      = 0;
    int bad        = 0;
    int starts     = 0;
    int start_wide = 0;

    // Multiplier model: not reset by rst, so an in-flight result can outlive a controller reset.
    logic signed [2*NB-1:0] mprod  = '0;
    logic                   mready = 1'b0;
    int unsigned            mcnt   = 0;

    always @(posedge clk) begin
        if (bus.mul_start) begin
            mprod  <= $signed({{NB{bus.mul_A[NB-1]}}, bus.mul_A}) *
                      $signed({{NB{bus.mul_B[NB-1]}}, bus.mul_B});
            mready <= 1'b0;
            mcnt   <= LAT;
        end else if (mcnt != 0) begin
            mcnt <= mcnt - 1;
            if (mcnt == 1) mready <= 1'b1;
        end
    end

    assign bus.mul_Product = mprod;
    assign bus.mul_ready   = mready;

    task automatic check(input string name, input int act, input int expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %0d (0x%0h) want %0d (0x%0h)", name, act, act, expv, expv);
        end
    endtask

    function automatic result_t mk(input int s, input logic o);
        result_t r;
        r.sum = ACCW'(s);
        r.ovf = o;
        return r;
    endfunction

    // Monitor: pops the scoreboard on every accepted result and tracks mul_start pulses.
    initial begin
        logic    prev_start;
        result_t r;
        prev_start = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (bus.mul_start) begin
                    starts++;
                    if (prev_start) start_wide++;
                end
                prev_start = bus.mul_start;
                if (bus.out_valid && bus.out_ready) begin
                    if (exp_q.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL unexpected_out: got sum 0x%0h with no result pending", bus.out_sum);
                    end else begin
                        r = exp_q.pop_front();
                        check("out_sum", 32'(bus.out_sum), 32'(r.sum));
                        check("out_ovf", 32'(bus.out_ovf), 32'(r.ovf));
                    end
                end
            end else begin
                prev_start = 1'b0;
            end
        end
    end

    task automatic push(input int a, input int b, input logic last);
        logic ok;
        int   n;
        bus.in_valid = 1'b1;
        bus.in_a     = NB'(a);
        bus.in_b     = NB'(b);
        bus.in_last  = last;
        n = 0;
        do begin
            @(negedge clk);
            ok = bus.in_ready;
            @(posedge clk);
            #1;
            n++;
        end while (!ok && n < 300);
        if (!ok) check("push_timeout", 0, 1);
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 1500) begin
            @(posedge clk);
            n++;
        end
        #1;
        check({name, "_drain"}, exp_q.size(), 0);
    endtask

    task automatic wait_start(input int base);
        int n;
        n = 0;
        while (starts == base && n < 300) begin
            @(negedge clk);
            n++;
        end
        check("wait_start", int'(starts > base), 1);
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_in_ready"},  32'(bus.in_ready),  1);
        check({tag, "_busy"},      32'(busy),          0);
        check({tag, "_out_valid"}, 32'(bus.out_valid), 0);
        check({tag, "_mul_start"}, 32'(bus.mul_start), 0);
        check({tag, "_mul_A"},     32'(bus.mul_A),     0);
        check({tag, "_mul_B"},     32'(bus.mul_B),     0);
        check({tag, "_out_sum"},   32'(bus.out_sum),   0);
        check({tag, "_out_ovf"},   32'(bus.out_ovf),   0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int unstable;
        int n;
        bus.in_valid  = 1'b0;
        bus.in_a      = '0;
        bus.in_b      = '0;
        bus.in_last   = 1'b0;
        bus.out_ready = 1'b1;

        // Reset state
        #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_reset_values("reset");
        rst = 1'b0;

        // Three-pair group: 12 - 30 - 14
        exp_q.push_back(mk(-32, 1'b0));
        push(3, 4, 1'b0);
        push(-5, 6, 1'b0);
        push(7, -2, 1'b1);
        drain("grp3");

        // Single most-negative square, one start pulse
        starts     = 0;
        start_wide = 0;
        exp_q.push_back(mk(16384, 1'b0));
        push(-128, -128, 1'b1);
        drain("sq");
        repeat (3) @(posedge clk);
        #1;
        check("sq_starts", starts, 1);
        check("sq_start_wide", start_wide, 0);

        // Backpressure on the result: held stable, then next group starts from zero
        bus.out_ready = 1'b0;
        exp_q.push_back(mk(-63, 1'b0));
        push(9, -7, 1'b1);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.out_valid && n < 300);
        check("hold_rise", 32'(bus.out_valid), 1);
        unstable = 0;
        repeat (20) begin
            @(negedge clk);
            if (!bus.out_valid || bus.out_sum !== ACCW'(-63) || bus.out_ovf !== 1'b0) unstable++;
        end
        check("hold_stable", unstable, 0);
        @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
        exp_q.push_back(mk(1, 1'b0));
        push(1, 1, 1'b1);
        drain("hold");

        // FIFO fills while the first pair waits on the multiplier
        exp_q.push_back(mk(9, 1'b0));
        base = starts;
        push(1, 1, 1'b0);
        wait_start(base);
        repeat (4) push(1, 1, 1'b0);
        @(negedge clk);
        check("full_in_ready", 32'(bus.in_ready), 0);
        check("full_busy", 32'(busy), 1);
        base = starts;
        @(posedge clk);
        #1;
        push(2, 2, 1'b1);
        check("fifth_after_issue", int'(starts > base), 1);
        drain("full");

        // 32 x 16384 wraps to the most negative accumulator value
        exp_q.push_back(mk(-524288, 1'b1));
        for (int i = 0; i < 32; i++) push(-128, -128, (i == 31));
        drain("wrap");

        // Next group after an overflowing one starts clean
        exp_q.push_back(mk(-20, 1'b0));
        push(4, -5, 1'b1);
        drain("post_wrap");

        // Reset during WAIT, then a fresh group after the stale result has landed
        base = starts;
        push(10, 10, 1'b1);
        wait_start(base);
        check("wait_busy", 32'(busy), 1);
        rst = 1'b1;
        #1;
        check_reset_values("midrst");
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (12) @(posedge clk);
        #1;
        check("rst_idle_busy", 32'(busy), 0);
        exp_q.push_back(mk(6, 1'b0));
        push(2, 3, 1'b1);
        drain("after_rst");

        repeat (5) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
